// File: rtl/msi_pkg.sv
// Shared MSI types: line states, bus snoop opcodes and the snoop FSM encoding.
package msi_pkg;

    typedef enum logic [1:0] {
        I = 2'b00,
        S = 2'b01,
        M = 2'b10
    } msi_state_t;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        BUS_RD   = 2'b01,
        BUS_RDX  = 2'b10,
        BUS_UPGR = 2'b11
    } bus_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOOKUP = 2'b01,
        ST_FLUSH  = 2'b10,
        ST_ACK    = 2'b11
    } snp_fsm_t;

    // Raw 2-bit state from the processor side; the unused encoding reads as invalid.
    function automatic msi_state_t to_msi_state(input logic [1:0] raw);
        msi_state_t st;
        case (raw)
            2'b01:   st = S;
            2'b10:   st = M;
            default: st = I;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/msi_line_array.sv
// Direct-mapped tag/state/data register file: one write port, two async read ports.
module msi_line_array
    import msi_pkg::*;
#(
    parameter int unsigned IDX_W  = 2,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    // snoop state-only update (takes priority)
    input  logic              snp_we_i,
    input  logic [IDX_W-1:0]  snp_index_i,
    input  msi_state_t        snp_state_i,
    // local full-line update
    input  logic              lu_we_i,
    input  logic [IDX_W-1:0]  lu_index_i,
    input  logic [TAG_W-1:0]  lu_tag_i,
    input  msi_state_t        lu_state_i,
    input  logic [DATA_W-1:0] lu_data_i,
    // snoop lookup port
    input  logic [IDX_W-1:0]  lk_index_i,
    output logic [TAG_W-1:0]  lk_tag_o,
    output msi_state_t        lk_state_o,
    output logic [DATA_W-1:0] lk_data_o,
    // processor read port
    input  logic [IDX_W-1:0]  rd_index_i,
    output logic [TAG_W-1:0]  rd_tag_o,
    output msi_state_t        rd_state_o,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int unsigned LINES = 2 ** IDX_W;

    logic [TAG_W-1:0]  tag_q   [LINES];
    msi_state_t        state_q [LINES];
    logic [DATA_W-1:0] data_q  [LINES];

    // Single write port: snoop changes only the state, local update rewrites the whole line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < LINES; i++) begin
                tag_q[i]   <= '0;
                state_q[i] <= I;
                data_q[i]  <= '0;
            end
        end else if (snp_we_i) begin
            state_q[snp_index_i] <= snp_state_i;
        end else if (lu_we_i) begin
            tag_q[lu_index_i]   <= lu_tag_i;
            state_q[lu_index_i] <= lu_state_i;
            data_q[lu_index_i]  <= lu_data_i;
        end
    end

    // Combinational reads, no write bypass.
    always_comb begin
        lk_tag_o   = tag_q[lk_index_i];
        lk_state_o = state_q[lk_index_i];
        lk_data_o  = data_q[lk_index_i];
        rd_tag_o   = tag_q[rd_index_i];
        rd_state_o = state_q[rd_index_i];
        rd_data_o  = data_q[rd_index_i];
    end

endmodule

// File: rtl/msi_snoop_responder.sv
// Snoop-side MSI controller: applies bus snoop transitions to the local line
// array and flushes dirty data when the line is held in M.
module msi_snoop_responder
    import msi_pkg::*;
#(
    parameter int unsigned CPU_ID = 0,
    parameter int unsigned ID_W   = 2,
    parameter int unsigned IDX_W  = 2,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DATA_W = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   snp_valid,
    output logic                   snp_ready,
    input  logic [1:0]             snp_op,
    input  logic [ID_W-1:0]        snp_src,
    input  logic [TAG_W+IDX_W-1:0] snp_addr,
    output logic                   snp_done,
    output logic                   snp_shared,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [TAG_W+IDX_W-1:0] wb_addr,
    output logic [DATA_W-1:0]      wb_data,
    input  logic                   lu_valid,
    output logic                   lu_ready,
    input  logic [IDX_W-1:0]       lu_index,
    input  logic [TAG_W-1:0]       lu_tag,
    input  logic [1:0]             lu_state,
    input  logic [DATA_W-1:0]      lu_data,
    input  logic [IDX_W-1:0]       rd_index,
    output logic [TAG_W-1:0]       rd_tag,
    output logic [1:0]             rd_state,
    output logic [DATA_W-1:0]      rd_data
);

    localparam int unsigned ADDR_W = TAG_W + IDX_W;

    snp_fsm_t            fsm_q, fsm_d;
    bus_op_t             op_q, op_d;
    logic [ID_W-1:0]     src_q, src_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                done_q, done_d;
    logic                shared_q, shared_d;
    logic                wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;

    logic                snp_req;
    logic                lu_we;
    logic                st_we;
    msi_state_t          st_new;
    logic [IDX_W-1:0]    snp_idx;
    logic [TAG_W-1:0]    snp_tag;
    logic [TAG_W-1:0]    lk_tag;
    msi_state_t          lk_state;
    logic [DATA_W-1:0]   lk_data;
    msi_state_t          rd_state_s;
    logic                hit;
    logic                remote;

    assign snp_req   = snp_valid && (snp_op != 2'b00);
    assign snp_ready = (fsm_q == ST_IDLE);
    assign lu_ready  = (fsm_q == ST_IDLE) && !snp_req;
    assign lu_we     = lu_valid && lu_ready;
    assign snp_idx   = addr_q[IDX_W-1:0];
    assign snp_tag   = addr_q[ADDR_W-1:IDX_W];
    assign hit       = (lk_state != I) && (lk_tag == snp_tag);
    assign remote    = (src_q != ID_W'(CPU_ID));

    msi_line_array #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_lines (
        .clock       (clock),
        .reset_n     (reset_n),
        .snp_we_i    (st_we),
        .snp_index_i (snp_idx),
        .snp_state_i (st_new),
        .lu_we_i     (lu_we),
        .lu_index_i  (lu_index),
        .lu_tag_i    (lu_tag),
        .lu_state_i  (to_msi_state(lu_state)),
        .lu_data_i   (lu_data),
        .lk_index_i  (snp_idx),
        .lk_tag_o    (lk_tag),
        .lk_state_o  (lk_state),
        .lk_data_o   (lk_data),
        .rd_index_i  (rd_index),
        .rd_tag_o    (rd_tag),
        .rd_state_o  (rd_state_s),
        .rd_data_o   (rd_data)
    );

    assign rd_state = rd_state_s;

    // Next-state, snoop transition and registered-output logic.
    always_comb begin
        fsm_d      = fsm_q;
        op_d       = op_q;
        src_d      = src_q;
        addr_d     = addr_q;
        done_d     = 1'b0;
        shared_d   = shared_q;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        st_we      = 1'b0;
        st_new     = I;

        case (fsm_q)
            ST_IDLE: begin
                if (snp_req) begin
                    op_d   = bus_op_t'(snp_op);
                    src_d  = snp_src;
                    addr_d = snp_addr;
                    fsm_d  = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                shared_d = hit;
                fsm_d    = ST_ACK;
                done_d   = 1'b1;
                if (remote && hit) begin
                    case (op_q)
                        BUS_RD: begin
                            if (lk_state == M) begin
                                st_we  = 1'b1;
                                st_new = S;
                            end
                        end
                        BUS_RDX, BUS_UPGR: begin
                            st_we  = 1'b1;
                            st_new = I;
                        end
                        default: ;
                    endcase
                    // Dirty data goes out on BusRd/BusRdX; BusUpgr on M is treated as S.
                    if ((lk_state == M) && ((op_q == BUS_RD) || (op_q == BUS_RDX))) begin
                        wb_valid_d = 1'b1;
                        wb_addr_d  = addr_q;
                        wb_data_d  = lk_data;
                        fsm_d      = ST_FLUSH;
                        done_d     = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                if (wb_ready) begin
                    wb_valid_d = 1'b0;
                    fsm_d      = ST_ACK;
                    done_d     = 1'b1;
                end
            end
            ST_ACK: begin
                fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q      <= ST_IDLE;
            op_q       <= NONE;
            src_q      <= '0;
            addr_q     <= '0;
            done_q     <= 1'b0;
            shared_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            fsm_q      <= fsm_d;
            op_q       <= op_d;
            src_q      <= src_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            shared_q   <= shared_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign snp_done   = done_q;
    assign snp_shared = shared_q;
    assign wb_valid   = wb_valid_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_msi_snoop_responder.sv
// Directed bench for msi_snoop_responder: table of single-snoop scenarios plus
// hand-written sequences for snoop/local-update collision and reset mid-flush.
module tb_msi_snoop_responder;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       snp_valid = 1'b0;
    logic       snp_ready;
    logic [1:0] snp_op = 2'b00;
    logic [1:0] snp_src = 2'b00;
    logic [4:0] snp_addr = '0;
    logic       snp_done;
    logic       snp_shared;
    logic       wb_valid;
    logic       wb_ready = 1'b0;
    logic [4:0] wb_addr;
    logic [3:0] wb_data;
    logic       lu_valid = 1'b0;
    logic       lu_ready;
    logic [1:0] lu_index = '0;
    logic [2:0] lu_tag = '0;
    logic [1:0] lu_state = '0;
    logic [3:0] lu_data = '0;
    logic [1:0] rd_index = '0;
    logic [2:0] rd_tag;
    logic [1:0] rd_state;
    logic [3:0] rd_data;

    int n_chk  = 0;
    int n_pass = 0;

    msi_snoop_responder #(
        .CPU_ID (0), .ID_W (2), .IDX_W (2), .TAG_W (3), .DATA_W (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .snp_valid  (snp_valid),
        .snp_ready  (snp_ready),
        .snp_op     (snp_op),
        .snp_src    (snp_src),
        .snp_addr   (snp_addr),
        .snp_done   (snp_done),
        .snp_shared (snp_shared),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_index   (lu_index),
        .lu_tag     (lu_tag),
        .lu_state   (lu_state),
        .lu_data    (lu_data),
        .rd_index   (rd_index),
        .rd_tag     (rd_tag),
        .rd_state   (rd_state),
        .rd_data    (rd_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        int idx;      // line index (snoop uses the same index)
        int tag;      // preloaded tag
        int st;       // preloaded raw state
        int data;     // preloaded data
        int op;       // snoop opcode
        int src;      // snoop source id
        int stag;     // snoop tag
        int stall;    // wb_ready stall cycles
        int e_shared;
        int e_flush;
        int e_state;  // state after the snoop
        int e_lat;    // accept -> snp_done cycles
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int  cyc;
        int  stalls;
        bit  done;
        bit  flush_seen;
        lu_valid = 1'b1;
        lu_index = 2'(v.idx);
        lu_tag   = 3'(v.tag);
        lu_state = 2'(v.st);
        lu_data  = 4'(v.data);
        step();
        lu_valid = 1'b0;

        snp_valid = 1'b1;
        snp_op    = 2'(v.op);
        snp_src   = 2'(v.src);
        snp_addr  = 5'(v.stag * 4 + v.idx);
        chk("snp_ready_before_accept", int'(snp_ready), 1);
        step();
        snp_valid = 1'b0;
        snp_op    = 2'b00;

        cyc = 1;
        stalls = 0;
        done = 1'b0;
        flush_seen = 1'b0;
        while (!done && cyc < 20) begin
            if (wb_valid) begin
                if (!flush_seen) begin
                    flush_seen = 1'b1;
                    chk("wb_addr", int'(wb_addr), v.stag * 4 + v.idx);
                    chk("wb_data", int'(wb_data), v.data);
                end
                if (stalls < v.stall) begin
                    wb_ready = 1'b0;
                    stalls++;
                end else begin
                    wb_ready = 1'b1;
                end
            end else begin
                wb_ready = 1'b0;
            end
            if (snp_done) begin
                done = 1'b1;
                chk("done_latency", cyc, v.e_lat);
                chk("snp_shared", int'(snp_shared), v.e_shared);
                chk("wb_valid_in_ack", int'(wb_valid), 0);
            end else begin
                step();
                cyc++;
            end
        end
        if (!done) chk("snp_done_timeout", 0, 1);
        chk("flush_seen", int'(flush_seen), v.e_flush);
        wb_ready = 1'b0;
        step();
        rd_index = 2'(v.idx);
        #1;
        chk("done_single_pulse", int'(snp_done), 0);
        chk("rd_state", int'(rd_state), v.e_state);
        chk("rd_tag", int'(rd_tag), v.tag);
        chk("rd_data", int'(rd_data), v.data);
    endtask

    initial begin
        int  cyc;
        bit  saw_done;

        //           idx tag st data op src stag stall sh fl est lat
        vecs[0] = '{1, 5, 2, 10, 1, 1, 5, 2, 1, 1, 1, 5}; // BusRd on M, stalled flush
        vecs[1] = '{2, 3, 1,  6, 2, 2, 3, 0, 1, 0, 0, 2}; // BusRdX on S
        vecs[2] = '{0, 1, 2,  9, 1, 1, 2, 0, 0, 0, 2, 2}; // tag miss on M
        vecs[3] = '{3, 7, 2, 12, 2, 0, 7, 0, 1, 0, 2, 2}; // own snoop on M
        vecs[4] = '{1, 2, 2,  5, 2, 3, 2, 1, 1, 1, 0, 4}; // BusRdX on M, 1 stall
        vecs[5] = '{2, 4, 2, 15, 3, 1, 4, 0, 1, 0, 0, 2}; // BusUpgr on M treated as S
        vecs[6] = '{0, 6, 1,  3, 3, 2, 6, 0, 1, 0, 0, 2}; // BusUpgr on S
        vecs[7] = '{3, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0, 2}; // invalid line, tag matches
        vecs[8] = '{1, 1, 3,  7, 1, 1, 1, 0, 0, 0, 0, 2}; // lu state 11 reads as I
        vecs[9] = '{2, 5, 1,  4, 1, 3, 5, 0, 1, 0, 1, 2}; // BusRd on S

        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rst_snp_ready", int'(snp_ready), 1);
        chk("rst_snp_done", int'(snp_done), 0);
        chk("rst_snp_shared", int'(snp_shared), 0);
        chk("rst_wb_valid", int'(wb_valid), 0);
        chk("rst_wb_addr", int'(wb_addr), 0);
        chk("rst_wb_data", int'(wb_data), 0);
        for (int i = 0; i < 4; i++) begin
            rd_index = 2'(i);
            #1;
            chk("rst_line_state", int'(rd_state), 0);
            chk("rst_line_tag", int'(rd_tag), 0);
            chk("rst_line_data", int'(rd_data), 0);
        end

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // snp_op NONE is ignored and does not block a local update
        snp_valid = 1'b1;
        snp_op    = 2'b00;
        #1;
        chk("none_lu_ready", int'(lu_ready), 1);
        step();
        chk("none_not_accepted", int'(snp_ready), 1);
        step();
        chk("none_no_done", int'(snp_done), 0);
        snp_valid = 1'b0;

        // Snoop and local update in the same IDLE cycle: snoop first, update after ACK.
        // Line 0 holds tag 6 in I (vector 6), so the BusRd misses.
        snp_valid = 1'b1;
        snp_op    = 2'b01;
        snp_src   = 2'd1;
        snp_addr  = 5'(1 * 4 + 0);
        lu_valid  = 1'b1;
        lu_index  = 2'd0;
        lu_tag    = 3'd1;
        lu_state  = 2'b10;
        lu_data   = 4'd8;
        #1;
        chk("coll_lu_ready_low", int'(lu_ready), 0);
        step();
        snp_valid = 1'b0;
        snp_op    = 2'b00;
        chk("coll_lu_ready_lookup", int'(lu_ready), 0);
        step();
        chk("coll_done", int'(snp_done), 1);
        chk("coll_shared", int'(snp_shared), 0);
        chk("coll_lu_ready_ack", int'(lu_ready), 0);
        step();
        chk("coll_lu_ready_idle", int'(lu_ready), 1);
        step();
        lu_valid = 1'b0;
        rd_index = 2'd0;
        #1;
        chk("coll_lu_state", int'(rd_state), 2);
        chk("coll_lu_tag", int'(rd_tag), 1);
        chk("coll_lu_data", int'(rd_data), 8);

        // Reset asserted while a flush waits on wb_ready.
        wb_ready  = 1'b0;
        snp_valid = 1'b1;
        snp_op    = 2'b01;
        snp_src   = 2'd2;
        snp_addr  = 5'(1 * 4 + 0);
        step();
        snp_valid = 1'b0;
        snp_op    = 2'b00;
        step();
        chk("rstf_wb_valid_up", int'(wb_valid), 1);
        chk("rstf_wb_data", int'(wb_data), 8);
        step();
        reset_n = 1'b0;
        #1;
        chk("rstf_wb_valid_drop", int'(wb_valid), 0);
        chk("rstf_done_low", int'(snp_done), 0);
        for (int i = 0; i < 4; i++) begin
            rd_index = 2'(i);
            #1;
            chk("rstf_state_i", int'(rd_state), 0);
        end
        step();
        reset_n = 1'b1;
        #1;
        chk("rstf_snp_ready", int'(snp_ready), 1);
        saw_done = 1'b0;
        for (cyc = 0; cyc < 6; cyc++) begin
            step();
            if (snp_done || wb_valid) saw_done = 1'b1;
        end
        chk("rstf_no_completion", int'(saw_done), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
